// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder/subtractor: the controller state
// encoding and the default operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// fullAdder
// One-bit full adder cell shared across the codebase.
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : fullAdder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder/subtractor. One operand bit per clock, LSB first, through a
// single full-adder cell with a registered carry. An operation takes WIDTH RUN
// cycles followed by one DONE cycle in which done pulses.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   start  - request an operation (accepted only in IDLE)
//   a, b   - operands (captured on acceptance)
//   cin    - carry in, add mode only
//   sub    - 0: a + b + cin, 1: a - b
//   sum    - result, valid from DONE until the next accepted start
//   cout   - carry out (subtract: 1 = no borrow)
//   ovf    - signed overflow
//   busy   - high in RUN and DONE
//   done   - one-cycle result-valid pulse
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int                 CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic               sub_r;
    logic               carry_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

    logic               fa_b_s;
    logic               fa_sum_s;
    logic               fa_cout_s;
    logic [WIDTH-1:0]   sum_next_s;

    // Subtraction adds the one's complement of B; the +1 comes from the initial carry.
    assign fa_b_s = b_sh_r[0] ^ sub_r;

    fullAdder u_fa (
        .a    (a_sh_r[0]),
        .b    (fa_b_s),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Result shift register: new bit enters at the MSB, older bits move toward the LSB.
    always_comb begin
        sum_next_s            = sum_r >> 1'b1;
        sum_next_s[WIDTH-1]   = fa_sum_s;
    end

    // Controller and datapath state; all outputs come straight from these registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        sub_r   <= sub;
                        carry_r <= sub ? 1'b1 : cin;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh_r  <= a_sh_r >> 1'b1;
                    b_sh_r  <= b_sh_r >> 1'b1;
                    carry_r <= fa_cout_s;
                    sum_r   <= sum_next_s;
                    cnt_r   <= cnt_r + 1'b1;
                    if (cnt_r == LAST_BIT) begin
                        // carry_r still holds the carry into the MSB here.
                        cout_r  <= fa_cout_s;
                        ovf_r   <= carry_r ^ fa_cout_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder: a WIDTH=8 instance driven from a vector
// table plus hand-written corner sequences, and a WIDTH=1 instance swept over
// all add-mode input combinations. Expected results go into a queue when an
// operation is launched and are popped when done is observed.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;

    logic       rst8, start8, cin8, sub8;
    logic [7:0] a8, b8, sum8;
    logic       cout8, ovf8, busy8, done8;

    logic       rst1, start1, cin1, sub1;
    logic [0:0] a1, b1, sum1;
    logic       cout1, ovf1, busy1, done1;

    int   errors = 0;
    int   checks = 0;
    exp_t q8[$];
    exp_t q1[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sub(sub8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .sub(sub1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at the negedge just after the accepting edge; waits for done,
    // checks latency, result and the following quiet cycle.
    task automatic wait_done8(input string nm);
        int   cyc;
        exp_t e;
        cyc = 1;
        chk({nm, "_busy_run"}, 32'(busy8), 32'd1);
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'd9);
        chk({nm, "_busy_done"}, 32'(busy8), 32'd1);
        if (q8.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = q8.pop_front();
            chk({nm, "_sum"}, 32'(sum8), 32'(e.sum));
            chk({nm, "_cout"}, 32'(cout8), 32'(e.cout));
            chk({nm, "_ovf"}, 32'(ovf8), 32'(e.ovf));
            @(negedge clk);
            chk({nm, "_done_pulse"}, 32'(done8), 32'd0);
            chk({nm, "_busy_idle"}, 32'(busy8), 32'd0);
            chk({nm, "_sum_held"}, 32'(sum8), 32'(e.sum));
        end
    endtask

    task automatic run8(input vec_t v, input string nm);
        exp_t e;
        @(negedge clk);
        a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; start8 = 1'b1;
        e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~v.a; b8 = ~v.b;
        wait_done8(nm);
    endtask

    task automatic run1(input logic ta, input logic tb, input logic tc, input string nm);
        exp_t e;
        int   cyc;
        int   tot;
        tot    = int'(ta) + int'(tb) + int'(tc);
        e.sum  = 8'(tot % 2);
        e.cout = (tot >= 2);
        e.ovf  = tc ^ e.cout;
        q1.push_back(e);
        @(negedge clk);
        a1 = ta; b1 = tb; cin1 = tc; sub1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'd2);
        e = q1.pop_front();
        chk({nm, "_cout_sum"}, {30'd0, cout1, sum1}, {30'd0, e.cout, e.sum[0]});
        chk({nm, "_ovf"}, 32'(ovf1), 32'(e.ovf));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done1), 32'd0);
    endtask

    initial begin
        int   cyc;
        exp_t e;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
        tbl[5] = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

        rst8 = 1'b1; start8 = 1'b1; a8 = 8'h55; b8 = 8'h33; cin8 = 1'b1; sub8 = 1'b0;
        rst1 = 1'b1; start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sub1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset holds everything at zero even with start asserted.
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst1_busy", 32'(busy1), 32'd0);
        rst8 = 1'b0; start8 = 1'b0;
        rst1 = 1'b0; start1 = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run8(tbl[i], $sformatf("vec%0d", i));
        end

        // Start held high with operands changing during RUN.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        e.sum = 8'h46; e.cout = 1'b0; e.ovf = 1'b0;
        q8.push_back(e);
        @(negedge clk);
        cyc = 1;
        chk("hold_busy", 32'(busy8), 32'd1);
        while (!done8 && cyc < 40) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("hold_latency", 32'(cyc), 32'd9);
        e = q8.pop_front();
        chk("hold_sum", 32'(sum8), 32'(e.sum));
        chk("hold_cout", 32'(cout8), 32'(e.cout));
        chk("hold_ovf", 32'(ovf8), 32'(e.ovf));
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0;
        e.sum = 8'h03; e.cout = 1'b0; e.ovf = 1'b0;
        q8.push_back(e);
        @(negedge clk);
        chk("hold_done_ignored", 32'(busy8), 32'd0);
        chk("hold_single_done", 32'(done8), 32'd0);
        @(negedge clk);
        chk("hold_reaccept", 32'(busy8), 32'd1);
        start8 = 1'b0;
        wait_done8("hold2");

        // Reset in RUN cycle 3 aborts; a start at the first edge after release is accepted.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_sum", 32'(sum8), 32'd0);
        chk("abort_cout", 32'(cout8), 32'd0);
        chk("abort_ovf", 32'(ovf8), 32'd0);
        rst8 = 1'b0;
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        e.sum = 8'h4C; e.cout = 1'b0; e.ovf = 1'b0;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        wait_done8("post_rst");

        // WIDTH=1: every {a, b, cin} in add mode.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] bits;
            bits = 3'(i);
            run1(bits[2], bits[1], bits[0], $sformatf("w1_%0d", i));
        end

        chk("sb8_drained", 32'(q8.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-008 The block SHALL have port sub, input, 1 bit: mode select, 0 = A+B+cin, 1 = A-B.
REQ-009 The block SHALL have port sum, output, WIDTH bits: result.
REQ-010 The block SHALL have port cout, output, 1 bit: carry-out; in subtract mode, 1 = no borrow.
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-012 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL latch a, b, cin and sub, clear the bit counter to 0, and move to RUN.
REQ-016 Operands SHALL be captured only at acceptance; input changes after acceptance SHALL have no effect.
REQ-017 Subtract mode SHALL use the latched B inverted and an initial carry of 1; cin SHALL be ignored.
REQ-018 Each RUN cycle SHALL add exactly one bit position, LSB first, through one full-adder cell plus a registered carry, and SHALL increment the counter.
REQ-019 After the cycle that processes bit WIDTH-1, the block SHALL move to DONE.
REQ-020 Timing SHALL be: accept at edge k, RUN for edges k+1..k+WIDTH, done=1 for exactly the cycle following edge k+WIDTH.
REQ-021 Total latency from accepting edge to done SHALL therefore be WIDTH+1 cycles.
REQ-022 DONE SHALL return to IDLE unconditionally.
REQ-023 A start seen in DONE SHALL be ignored; the earliest next acceptance is the edge after DONE.
REQ-024 busy SHALL be 1 exactly in RUN and DONE.
REQ-025 A start seen while busy SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-026 sum, cout and ovf SHALL be valid from the DONE cycle and held stable until the next accepted start.
REQ-027 While in RUN, sum, cout and ovf are undefined.
REQ-028 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-029 For WIDTH=1, the carry into the MSB SHALL be the initial carry.
REQ-030 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL wrap to 0 only on a new acceptance.

Reset
REQ-031 While reset=1 at an edge, the block SHALL enter IDLE and set sum=0, cout=0, ovf=0, busy=0, done=0, counter=0 and carry=0.
REQ-032 Reset SHALL take priority over start.
REQ-033 Reset during RUN or DONE SHALL abort the operation with no done pulse.
REQ-034 A start presented at the first edge after reset is released SHALL be accepted.

Structure
REQ-035 A shared package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant DEFAULT_WIDTH=8.
REQ-036 The per-bit add SHALL be done by instantiating the team's existing fullAdder sub-module (ports a, b, cin, sum, cout), one instance only.
REQ-037 The result SHALL be assembled in a WIDTH-bit shift register, filled from the MSB end and shifted right each RUN cycle.

Verification
REQ-038 The bench SHALL check: WIDTH=8, a=0xFF, b=0x01, cin=0, sub=0, start pulse -> done exactly 9 cycles after accept, sum=0x00, cout=1, ovf=0.
REQ-039 The bench SHALL check: WIDTH=8, a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1.
REQ-040 The bench SHALL check: WIDTH=8, a=0x05, b=0x07, sub=1, cin=1 (ignored) -> sum=0xFE, cout=0, ovf=0.
REQ-041 The bench SHALL check: start held high and operands changed during RUN -> a single done with the first operands' result, and a second acceptance only after DONE.
REQ-042 The bench SHALL check: reset asserted at RUN cycle 3 -> busy=0, done never pulses, and all outputs are 0 on the next cycle.
REQ-043 The bench SHALL check: WIDTH=1 with all 8 combinations of {a, b, cin} and sub=0 -> {cout, sum} equals a+b+cin, with done 2 cycles after each accept.
